// File: rtl/ahb_slave_pkg.sv
// Shared AHB-Lite encodings and slave FSM states for the on-chip memory slave.
package ahb_slave_pkg;

  typedef enum logic [1:0] {
    HT_IDLE = 2'd0, HT_BUSY = 2'd1, HT_NONSEQ = 2'd2, HT_SEQ = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HS_BYTE = 3'd0, HS_HALF = 3'd1, HS_WORD = 3'd2, HS_DWORD = 3'd3
  } hsize_e;

  typedef enum logic [2:0] {
    HB_SINGLE = 3'd0, HB_INCR = 3'd1, HB_WRAP4 = 3'd2, HB_INCR4 = 3'd3,
    HB_WRAP8 = 3'd4, HB_INCR8 = 3'd5, HB_WRAP16 = 3'd6, HB_INCR16 = 3'd7
  } hburst_e;

  typedef enum logic {HR_OKAY = 1'b0, HR_ERROR = 1'b1} hresp_e;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} slv_state_e;

  // Byte-lane mask for a transfer size, before shifting to the address offset.
  function automatic logic [7:0] size_mask(input logic [2:0] size);
    case (size)
      3'd0:    return 8'h01;
      3'd1:    return 8'h03;
      3'd2:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/ahb_mem_array.sv
// Word-organised memory with per-byte write enables and an asynchronous read port.
module ahb_mem_array
  import ahb_slave_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 256,
  localparam int NB    = DATA_WIDTH / 8,
  localparam int IDX_W = $clog2(MEM_DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      waddr_i,
  input  logic [NB-1:0]         be_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [IDX_W-1:0]      raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [NB-1:0][7:0] mem_q [MEM_DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < NB; b++) begin
        if (be_i[b]) mem_q[waddr_i][b] <= wdata_i[b*8 +: 8];
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite memory slave: phase registers, wait-state/error FSM, byte lanes, write-to-read forwarding.
// Define AHB_SLV_RANGE_ERR_EN to answer out-of-range word indices with ERROR instead of aliasing.
module ahb_slave_mem
  import ahb_slave_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int LOG2B = $clog2(NB);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [2:0] MAX_SIZE = 3'(LOG2B);

  slv_state_e            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q;
  logic [LOG2B-1:0]      off_q;
  logic [2:0]            size_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  accept, bad, load;
  logic [ADDR_WIDTH-1:0] amask;
  logic [IDX_W-1:0]      haddr_idx, rd_idx;
  logic                  rd_write, rd_load, wr_en, fwd;
  logic [NB-1:0]         wr_be;
  logic [DATA_WIDTH-1:0] mem_rd, rd_word;
  logic                  unused_in;

  assign unused_in = ^{HBURST, HTRANS[0], HADDR};

  assign accept    = HSEL && HREADY && (htrans_e'(HTRANS) inside {HT_NONSEQ, HT_SEQ});
  assign haddr_idx = HADDR[LOG2B +: IDX_W];
  assign amask     = (ADDR_WIDTH'(1) << HSIZE) - ADDR_WIDTH'(1);

  always_comb begin
    bad = (HSIZE > MAX_SIZE) || (|(HADDR & amask));
`ifdef AHB_SLV_RANGE_ERR_EN
    bad = bad || ((HADDR >> LOG2B) >= ADDR_WIDTH'(MEM_DEPTH));
`endif
  end

  // IDLE, DATA and ERR2 all present HREADYOUT=1 and may take a new address phase.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    load      = 1'b0;
    HREADYOUT = 1'b1;
    HRESP     = HR_OKAY;
    case (state_q)
      S_WAIT: begin
        HREADYOUT = 1'b0;
        cnt_d     = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_DATA;
      end
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HR_ERROR;
        state_d   = S_ERR2;
      end
      default: begin
        if (state_q == S_ERR2) HRESP = HR_ERROR;
        state_d = S_IDLE;
        if (accept) begin
          load = 1'b1;
          if (bad) begin
            state_d = S_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_STATES);
          end else begin
            state_d = S_DATA;
          end
        end
      end
    endcase
  end

  // Read data is captured on the edge entering DATA, so it comes from the live
  // address phase (zero-wait) or the registered one (after wait states).
  assign rd_idx   = (state_q == S_WAIT) ? idx_q : haddr_idx;
  assign rd_write = (state_q == S_WAIT) ? write_q : HWRITE;
  assign rd_load  = (state_d == S_DATA) && !rd_write;

  assign wr_en = (state_q == S_DATA) && write_q;
  assign wr_be = NB'(size_mask(size_q)) << off_q;
  assign fwd   = wr_en && (idx_q == rd_idx);

  for (genvar b = 0; b < NB; b++) begin : g_fwd
    assign rd_word[b*8 +: 8] = (fwd && wr_be[b]) ? HWDATA[b*8 +: 8] : mem_rd[b*8 +: 8];
  end

  ahb_mem_array #(.DATA_WIDTH(DATA_WIDTH), .MEM_DEPTH(MEM_DEPTH)) u_mem (
    .clk_i   (HCLK),
    .we_i    (wr_en),
    .waddr_i (idx_q),
    .be_i    (wr_be),
    .wdata_i (HWDATA),
    .raddr_i (rd_idx),
    .rdata_o (mem_rd)
  );

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      off_q   <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load) begin
        idx_q   <= haddr_idx;
        off_q   <= HADDR[LOG2B-1:0];
        size_q  <= HSIZE;
        write_q <= HWRITE;
      end
      if (rd_load) rdata_q <= rd_word;
    end
  end

  assign HRDATA = rdata_q;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Scoreboard bench: dut0 has zero wait states, dut1 has three; one shared address/data bus.
module tb_ahb_slave_mem;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [1:0]  hsel;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize, hburst;
  logic [31:0] hrdata0, hrdata1;
  logic        hrdy0, hrdy1, hresp0, hresp1;

  always #5 HCLK = ~HCLK;

  ahb_slave_mem #(.WAIT_STATES(0)) u_dut0 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel[0]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(hrdy0),
    .HRDATA(hrdata0), .HREADYOUT(hrdy0), .HRESP(hresp0));

  ahb_slave_mem #(.WAIT_STATES(3)) u_dut1 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel[1]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(hrdy1),
    .HRDATA(hrdata1), .HREADYOUT(hrdy1), .HRESP(hresp1));

  typedef struct {
    int          d;
    bit          rd;
    bit          err;
    int          waits;
    logic [31:0] data;
    string       tag;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  logic [31:0] mdl [2][256];
  int          n_chk = 0;
  int          n_err = 0;
  bit          dp [2];
  int          low [2];

  function automatic logic rdy(input int d);
    return (d != 0) ? hrdy1 : hrdy0;
  endfunction
  function automatic logic rsp(input int d);
    return (d != 0) ? hresp1 : hresp0;
  endfunction
  function automatic logic [31:0] rdat(input int d);
    return (d != 0) ? hrdata1 : hrdata0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Monitor: tracks each slave's data phase, counts stalled cycles, pops on completion.
  always @(negedge HCLK) begin
    if (HRESET === 1'b0) begin
      for (int d = 0; d < 2; d++) begin
        if (dp[d] && !rdy(d)) begin
          low[d]++;
          if (sbq.size() > 0) check({sbq[0].tag, "_resp_stall"}, 32'(rsp(d)), 32'(sbq[0].err));
        end else begin
          if (dp[d]) begin
            if (sbq.size() == 0) begin
              check("sb_empty_on_dphase", 32'(sbq.size()), 32'd1);
            end else begin
              mon_e = sbq.pop_front();
              check({mon_e.tag, "_waits"}, 32'(low[d]), 32'(mon_e.waits));
              check({mon_e.tag, "_resp"}, 32'(rsp(d)), 32'(mon_e.err));
              if (mon_e.rd && !mon_e.err) check({mon_e.tag, "_data"}, rdat(d), mon_e.data);
            end
          end
          dp[d]  = hsel[d] && rdy(d) && htrans[1];
          low[d] = 0;
        end
      end
    end
  end

  // Drives one NONSEQ address phase (called at posedge+1) and records the expected response.
  task automatic beat(input int d, input bit wr, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, input string tag);
    exp_t e;
    bit   bad;
    int   idx, lo, nbytes, guard;
    bad = (sz > 3'd2) || ((a & ((32'd1 << sz) - 32'd1)) != 32'd0);
`ifdef AHB_SLV_RANGE_ERR_EN
    bad = bad || ((a >> 2) >= 32'd256);
`endif
    idx     = int'((a >> 2) & 32'hFF);
    e.d     = d;
    e.rd    = !wr;
    e.err   = bad;
    e.waits = bad ? 1 : ((d != 0) ? 3 : 0);
    e.data  = mdl[d][idx];
    e.tag   = tag;
    if (wr && !bad) begin
      lo     = int'(a[1:0]);
      nbytes = 1 << sz;
      for (int b = 0; b < 4; b++)
        if (b >= lo && b < lo + nbytes) mdl[d][idx][b*8 +: 8] = wd[b*8 +: 8];
    end
    sbq.push_back(e);
    hsel   = 2'b01 << d;
    haddr  = a;
    htrans = 2'b10;
    hwrite = wr;
    hsize  = sz;
    guard  = 0;
    while (!rdy(d) && guard < 100) begin
      @(posedge HCLK); #1;
      guard++;
    end
    if (guard >= 100) check({tag, "_rdy_timeout"}, 32'(rdy(d)), 32'd1);
    @(posedge HCLK); #1;
    hsel   = 2'b00;
    htrans = 2'b00;
    hwdata = wd;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sbq.size() != 0 && g < 200) begin
      @(posedge HCLK);
      g++;
    end
    check("drain", 32'(sbq.size()), 32'd0);
    @(posedge HCLK); #1;
  endtask

  initial begin
    HRESET = 1'b1;
    hsel = '0; haddr = '0; htrans = '0; hwrite = 1'b0; hsize = '0; hburst = '0; hwdata = '0;
    repeat (3) @(posedge HCLK);
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_hold_rdy%0d", d),   32'(rdy(d)), 32'd1);
      check($sformatf("rst_hold_resp%0d", d),  32'(rsp(d)), 32'd0);
      check($sformatf("rst_hold_rdata%0d", d), rdat(d),     32'd0);
    end
    HRESET = 1'b0;
    repeat (2) @(posedge HCLK);
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_rel_rdy%0d", d),   32'(rdy(d)), 32'd1);
      check($sformatf("rst_rel_resp%0d", d),  32'(rsp(d)), 32'd0);
      check($sformatf("rst_rel_rdata%0d", d), rdat(d),     32'd0);
    end

    // Back-to-back write then read of the same word.
    beat(0, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF, "t2_wr");
    beat(0, 1'b0, 32'h10, 3'd2, 32'h0,        "t2_rd");
    drain();

    // Sub-word writes; write data sits on the lanes selected by the address.
    beat(0, 1'b1, 32'h10, 3'd2, 32'h11223344, "t3_word");
    beat(0, 1'b1, 32'h13, 3'd0, 32'hAA000000, "t3_byte");
    beat(0, 1'b1, 32'h14, 3'd2, 32'h55667788, "t3_word2");
    beat(0, 1'b1, 32'h16, 3'd1, 32'hBEEF0000, "t3_half");
    beat(0, 1'b1, 32'h15, 3'd0, 32'h0000CC00, "t3_byte1");
    beat(0, 1'b0, 32'h10, 3'd2, 32'h0,        "t3_rd10");
    beat(0, 1'b0, 32'h14, 3'd2, 32'h0,        "t3_rd14");
    drain();

    // Three wait states on both writes and reads.
    beat(1, 1'b1, 32'h20, 3'd2, 32'hCAFEF00D, "t4_wr");
    beat(1, 1'b0, 32'h20, 3'd2, 32'h0,        "t4_rd");
    beat(1, 1'b1, 32'h22, 3'd2, 32'hFFFFFFFF, "t4_mis");
    beat(1, 1'b0, 32'h20, 3'd2, 32'h0,        "t4_rd2");
    drain();

    // Misaligned and oversize transfers must not disturb memory.
    beat(0, 1'b1, 32'h00, 3'd2, 32'h12345678, "t5_init");
    beat(0, 1'b1, 32'h01, 3'd1, 32'hFFFFFFFF, "t5_mis");
    beat(0, 1'b1, 32'h00, 3'd3, 32'hFFFFFFFF, "t5_big");
    beat(0, 1'b0, 32'h00, 3'd2, 32'h0,        "t5_rd");
    drain();

    // Out-of-range word: ERROR when range checking is built in, else aliases to word 0.
    beat(0, 1'b1, 32'h400, 3'd2, 32'h0BADC0DE, "t6_hi");
    beat(0, 1'b0, 32'h000, 3'd2, 32'h0,        "t6_rd0");
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
